// File: rtl/hazard_unit_if.sv
// hazard_unit_if: datapath <-> hazard_unit bundle.
//   master: datapath side; drives stage register specifiers and status, receives stall/flush/forward controls.
//   slave : hazard_unit side.
//   CNT_W : width of the optional performance counters (HAZARD_PERF_EN).
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic [1:0] branchD;
    logic [4:0] RsD, RtD;
    logic       MultReadD;
    logic [4:0] RsE, RtE, WriteRegE;
    logic       RegWriteE;
    logic [2:0] WBSrcE;
    logic       MultStartE, MultDoneE;
    logic       RegWriteM;
    logic [2:0] WBSrcM;
    logic [4:0] WriteRegM;
    logic       RegWriteW;
    logic [4:0] WriteRegW;
    logic       stallF, stallD, flushE;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       multBusy;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stallCnt, flushCnt;
`endif

    modport master (
        output branchD, RsD, RtD, MultReadD, RsE, RtE, WriteRegE, RegWriteE, WBSrcE,
               MultStartE, MultDoneE, RegWriteM, WBSrcM, WriteRegM, RegWriteW, WriteRegW,
        input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE, multBusy
`ifdef HAZARD_PERF_EN
        , input stallCnt, flushCnt
`endif
    );

    modport slave (
        input  branchD, RsD, RtD, MultReadD, RsE, RtE, WriteRegE, RegWriteE, WBSrcE,
               MultStartE, MultDoneE, RegWriteM, WBSrcM, WriteRegM, RegWriteW, WriteRegW,
        output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE, multBusy
`ifdef HAZARD_PERF_EN
        , output stallCnt, flushCnt
`endif
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage MIPS core.
//   clk, rst : clock and synchronous active-high reset (all outputs forced to 0 while rst is high).
//   hz       : hazard_unit_if.slave; stage specifiers/status in, stallF/stallD/flushE,
//              forwardAD/BD (decode comparators), forwardAE/BE (ALU operands), multBusy out.
//   Optional: define HAZARD_PERF_EN to add saturating stallCnt/flushCnt counters.
module hazard_unit #(
    parameter logic [2:0] WBSRC_LOAD = 3'b001,
    parameter int         CNT_W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic       lwStall, brStall, mulStall, stall;
    logic       eHitsD, mLoadHitsD;
    logic [1:0] fwdAE, fwdBE;

    always_comb begin
        // M stage has priority: it holds the younger result.
        fwdAE = (hz.RsE != 5'd0 && hz.RegWriteM && hz.RsE == hz.WriteRegM) ? 2'b10 :
                (hz.RsE != 5'd0 && hz.RegWriteW && hz.RsE == hz.WriteRegW) ? 2'b01 : 2'b00;
        fwdBE = (hz.RtE != 5'd0 && hz.RegWriteM && hz.RtE == hz.WriteRegM) ? 2'b10 :
                (hz.RtE != 5'd0 && hz.RegWriteW && hz.RtE == hz.WriteRegW) ? 2'b01 : 2'b00;
        eHitsD = hz.RegWriteE && hz.WriteRegE != 5'd0 &&
                 (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD);
        mLoadHitsD = hz.RegWriteM && hz.WBSrcM == WBSRC_LOAD && hz.WriteRegM != 5'd0 &&
                     (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD);
        lwStall = eHitsD && hz.WBSrcE == WBSRC_LOAD;
        // Branches resolve in decode, so any producer still in E, or a load still in M, must wait.
        brStall = hz.branchD != 2'b00 && (eHitsD || mLoadHitsD);
        // Released in the cycle MultDoneE is high so the reader leaves decode on that edge.
        mulStall = hz.MultReadD && state == BUSY && !hz.MultDoneE;
        stall = !rst && (lwStall || brStall || mulStall);
    end

    assign hz.stallF    = stall;
    assign hz.stallD    = stall;
    assign hz.flushE    = stall;
    assign hz.forwardAE = rst ? 2'b00 : fwdAE;
    assign hz.forwardBE = rst ? 2'b00 : fwdBE;
    assign hz.forwardAD = !rst && hz.RsD != 5'd0 && hz.RegWriteM && hz.RsD == hz.WriteRegM;
    assign hz.forwardBD = !rst && hz.RtD != 5'd0 && hz.RegWriteM && hz.RtD == hz.WriteRegM;
    assign hz.multBusy  = !rst && state == BUSY;

    // A start with simultaneous done is a single-cycle multiply; a start while BUSY is ignored.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (state == BUSY)
            state <= hz.MultDoneE ? IDLE : BUSY;
        else
            state <= (hz.MultStartE && !hz.MultDoneE) ? BUSY : IDLE;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stallCntQ, flushCntQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (stall && !(&stallCntQ))
                stallCntQ <= stallCntQ + 1'b1;
            if (stall && !(&flushCntQ))
                flushCntQ <= flushCntQ + 1'b1;
        end
    end

    assign hz.stallCnt = rst ? '0 : stallCntQ;
    assign hz.flushCnt = rst ? '0 : flushCntQ;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table vectors, hand sequences and random stimulus against a reference model.
module tb_hazard_unit;
`ifdef HAZARD_PERF_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    typedef struct packed {
        logic [1:0] branchD;
        logic [4:0] RsD, RtD;
        logic       MultReadD;
        logic [4:0] RsE, RtE, WriteRegE;
        logic       RegWriteE;
        logic [2:0] WBSrcE;
        logic       MultStartE, MultDoneE;
        logic [4:0] WriteRegM;
        logic       RegWriteM;
        logic [2:0] WBSrcM;
        logic [4:0] WriteRegW;
        logic       RegWriteW;
    } in_t;

    typedef struct packed {
        logic       stallF, stallD, flushE, fAD, fBD;
        logic [1:0] fAE, fBE;
        logic       busy;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(CNT_W)) hz();
    hazard_unit #(.WBSRC_LOAD(3'b001), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hz(hz));

    int   tests = 0;
    int   fails = 0;
    in_t  curIn;
    logic curRst;
    bit   mBusy = 1'b0;
    longint mStall = 0;
    longint mFlush = 0;

    function automatic in_t mk(logic [1:0] br, logic [4:0] rsD, rtD, rsE, rtE, wrE, logic rwE,
                               logic [2:0] srcE, logic [4:0] wrM, logic rwM, logic [2:0] srcM,
                               logic [4:0] wrW, logic rwW);
        in_t v = '0;
        v.branchD = br; v.RsD = rsD; v.RtD = rtD; v.RsE = rsE; v.RtE = rtE;
        v.WriteRegE = wrE; v.RegWriteE = rwE; v.WBSrcE = srcE;
        v.WriteRegM = wrM; v.RegWriteM = rwM; v.WBSrcM = srcM;
        v.WriteRegW = wrW; v.RegWriteW = rwW;
        return v;
    endfunction

    function automatic out_t ex(logic s, logic fad, logic fbd, logic [1:0] fae, logic [1:0] fbe, logic b);
        return '{stallF: s, stallD: s, flushE: s, fAD: fad, fBD: fbd, fAE: fae, fBE: fbe, busy: b};
    endfunction

    // Reference: which stage supplies register r to an E-stage operand.
    function automatic logic [1:0] srcOf(logic [4:0] r, in_t v);
        if (r == 0) return 2'b00;
        if (v.RegWriteM && v.WriteRegM == r) return 2'b10;
        if (v.RegWriteW && v.WriteRegW == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit decodeReads(logic [4:0] r, in_t v);
        return r != 0 && (r == v.RsD || r == v.RtD);
    endfunction

    function automatic out_t model(in_t v, bit busy, logic r);
        bit loadUse, branchWait, mulWait, s;
        if (r) return '0;
        loadUse    = v.RegWriteE && v.WBSrcE == 3'd1 && decodeReads(v.WriteRegE, v);
        branchWait = v.branchD != 0 && ((v.RegWriteE && decodeReads(v.WriteRegE, v)) ||
                     (v.RegWriteM && v.WBSrcM == 3'd1 && decodeReads(v.WriteRegM, v)));
        mulWait    = v.MultReadD && busy && !v.MultDoneE;
        s = loadUse || branchWait || mulWait;
        return ex(s, srcOf(v.RsD, v) == 2'b10, srcOf(v.RtD, v) == 2'b10, srcOf(v.RsE, v), srcOf(v.RtE, v), busy);
    endfunction

    function automatic out_t got();
        return '{stallF: hz.stallF, stallD: hz.stallD, flushE: hz.flushE, fAD: hz.forwardAD,
                 fBD: hz.forwardBD, fAE: hz.forwardAE, fBE: hz.forwardBE, busy: hz.multBusy};
    endfunction

    task automatic apply(in_t v, logic r);
        curIn = v; curRst = r; rst = r;
        hz.branchD = v.branchD; hz.RsD = v.RsD; hz.RtD = v.RtD; hz.MultReadD = v.MultReadD;
        hz.RsE = v.RsE; hz.RtE = v.RtE; hz.WriteRegE = v.WriteRegE; hz.RegWriteE = v.RegWriteE;
        hz.WBSrcE = v.WBSrcE; hz.MultStartE = v.MultStartE; hz.MultDoneE = v.MultDoneE;
        hz.WriteRegM = v.WriteRegM; hz.RegWriteM = v.RegWriteM; hz.WBSrcM = v.WBSrcM;
        hz.WriteRegW = v.WriteRegW; hz.RegWriteW = v.RegWriteW;
        @(negedge clk);
    endtask

    task automatic tick();
        out_t m = model(curIn, mBusy, curRst);
        longint top = (64'd1 << CNT_W) - 1;
        if (curRst) begin
            mBusy = 0; mStall = 0; mFlush = 0;
        end else begin
            mBusy = mBusy ? !curIn.MultDoneE : (curIn.MultStartE && !curIn.MultDoneE);
            if (m.stallF && mStall < top) mStall++;
            if (m.flushE && mFlush < top) mFlush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, out_t e);
        out_t g = got();
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s: got sF/sD/fE/fAD/fBD/fAE/fBE/busy=%b required %b", name, g, e);
        end
    endtask

    task automatic step(string name, in_t v, logic r, out_t e);
        apply(v, r);
        check(name, e);
        tick();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic checkCnt(string name, longint es, longint ef);
        tests++;
        if (hz.stallCnt !== CNT_W'(es) || hz.flushCnt !== CNT_W'(ef)) begin
            fails++;
            $display("FAIL %s: got stallCnt=%0d flushCnt=%0d required %0d/%0d", name, hz.stallCnt, hz.flushCnt, es, ef);
        end
    endtask
`endif

    vec_t tv[14];
    in_t  z, v;
    out_t o;

    initial begin
        z = '0;
        tv[0]  = '{mk(0, 0, 0, 5, 0, 0, 0, 0, 5, 1, 0, 5, 1), ex(0, 0, 0, 2'b10, 2'b00, 0)};
        tv[1]  = '{mk(0, 0, 0, 5, 0, 0, 0, 0, 5, 0, 0, 5, 1), ex(0, 0, 0, 2'b01, 2'b00, 0)};
        tv[2]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), ex(0, 0, 0, 2'b00, 2'b00, 0)};
        tv[3]  = '{mk(0, 0, 0, 0, 7, 0, 0, 0, 3, 1, 0, 7, 1), ex(0, 0, 0, 2'b00, 2'b01, 0)};
        tv[4]  = '{mk(0, 0, 0, 4, 4, 0, 0, 0, 4, 1, 0, 0, 0), ex(0, 0, 0, 2'b10, 2'b10, 0)};
        tv[5]  = '{mk(0, 8, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0), ex(1, 0, 0, 2'b00, 2'b00, 0)};
        tv[6]  = '{mk(0, 0, 8, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0), ex(1, 0, 0, 2'b00, 2'b00, 0)};
        tv[7]  = '{mk(0, 8, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 2'b00, 2'b00, 0)};
        tv[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 2'b00, 2'b00, 0)};
        tv[9]  = '{mk(1, 9, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 2'b00, 2'b00, 0)};
        tv[10] = '{mk(1, 9, 0, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0), ex(1, 1, 0, 2'b00, 2'b00, 0)};
        tv[11] = '{mk(2, 0, 6, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0), ex(0, 0, 1, 2'b00, 2'b00, 0)};
        tv[12] = '{mk(0, 9, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 2'b00, 2'b00, 0)};
        tv[13] = '{mk(0, 8, 0, 0, 0, 8, 0, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 2'b00, 2'b00, 0)};

        // reset forces outputs low even with hazards present
        step("reset", tv[10].i, 1, '0);
        step("reset2", tv[0].i, 1, '0);

        foreach (tv[k]) step($sformatf("vec%0d", k), tv[k].i, 0, tv[k].e);

        // load-use: one stall, then forward from M
        step("lu_stall", mk(0, 8, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0), 0, ex(1, 0, 0, 2'b00, 2'b00, 0));
        step("lu_fwd", mk(0, 0, 0, 8, 0, 0, 0, 0, 8, 1, 1, 0, 0), 0, ex(0, 0, 0, 2'b10, 2'b00, 0));

        // branch directly after load: two stall cycles
        step("bl_1", mk(1, 9, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0), 0, ex(1, 0, 0, 2'b00, 2'b00, 0));
        step("bl_2", mk(1, 9, 0, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0), 0, ex(1, 1, 0, 2'b00, 2'b00, 0));
        step("bl_3", mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1), 0, ex(0, 0, 0, 2'b00, 2'b00, 0));

        // multiply: start, read 4 cycles, done on the 4th
        v = z; v.MultStartE = 1; v.MultReadD = 1;
        step("mul_c1", v, 0, ex(0, 0, 0, 0, 0, 0));
        v = z; v.MultReadD = 1;
        step("mul_c2", v, 0, ex(1, 0, 0, 0, 0, 1));
        v.MultStartE = 1;
        step("mul_c3", v, 0, ex(1, 0, 0, 0, 0, 1));
        v = z; v.MultReadD = 1; v.MultDoneE = 1;
        step("mul_c4", v, 0, ex(0, 0, 0, 0, 0, 1));
        step("mul_c5", z, 0, ex(0, 0, 0, 0, 0, 0));

        // single-cycle multiply stays idle
        v = z; v.MultStartE = 1; v.MultDoneE = 1;
        step("mul_1cyc", v, 0, ex(0, 0, 0, 0, 0, 0));
        step("mul_1cyc_after", z, 0, ex(0, 0, 0, 0, 0, 0));

        // reset mid-multiply, late done ignored
        v = z; v.MultStartE = 1;
        step("rm_start", v, 0, ex(0, 0, 0, 0, 0, 0));
        step("rm_busy", z, 0, ex(0, 0, 0, 0, 0, 1));
        v = mk(0, 0, 0, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0); v.MultReadD = 1;
        step("rm_rst", v, 1, '0);
        v = z; v.MultDoneE = 1;
        step("rm_late_done", v, 0, ex(0, 0, 0, 0, 0, 0));
        step("rm_after", z, 0, ex(0, 0, 0, 0, 0, 0));

`ifdef HAZARD_PERF_EN
        step("perf_rst", z, 1, '0);
        checkCnt("perf_zero", 0, 0);
        for (int k = 0; k < 3; k++)
            step("perf_lu", mk(0, 8, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0), 0, ex(1, 0, 0, 0, 0, 0));
        apply(z, 0);
        checkCnt("perf_three", 3, 3);
        tick();
        for (int k = 0; k < 20; k++)
            step("perf_sat", mk(0, 8, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0), 0, ex(1, 0, 0, 0, 0, 0));
        apply(z, 0);
        checkCnt("perf_hold", 15, 15);
        tick();
`endif

        // randomized stimulus against the reference model
        for (int n = 0; n < 600; n++) begin
            v.branchD    = 2'($urandom_range(0, 3));
            v.RsD        = 5'($urandom_range(0, 3));
            v.RtD        = 5'($urandom_range(0, 3));
            v.MultReadD  = 1'($urandom_range(0, 1));
            v.RsE        = 5'($urandom_range(0, 3));
            v.RtE        = 5'($urandom_range(0, 3));
            v.WriteRegE  = 5'($urandom_range(0, 3));
            v.RegWriteE  = 1'($urandom_range(0, 1));
            v.WBSrcE     = 3'($urandom_range(0, 2));
            v.MultStartE = $urandom_range(0, 3) == 0;
            v.MultDoneE  = $urandom_range(0, 2) == 0;
            v.WriteRegM  = 5'($urandom_range(0, 3));
            v.RegWriteM  = 1'($urandom_range(0, 1));
            v.WBSrcM     = 3'($urandom_range(0, 2));
            v.WriteRegW  = 5'($urandom_range(0, 3));
            v.RegWriteW  = 1'($urandom_range(0, 1));
            apply(v, $urandom_range(0, 29) == 0);
            o = model(v, mBusy, curRst);
            check("rand", o);
`ifdef HAZARD_PERF_EN
            if (!curRst) checkCnt("rand_cnt", mStall, mFlush);
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
